// File: rtl/ins_dispatch.sv
// ins_dispatch
//   Issues the host instruction stream one instruction at a time, in order,
//   to the load (ddr2pe), compute (pe_array) and store (pe2ddr) units.
//   Each instruction is held until its hazards clear. Hazards are tracked
//   with a per-buffer load scoreboard, a compute-busy flag and a counter of
//   outstanding stores.
//
//   Optional feature macro: INS_DISPATCH_PERF_EN
//     When defined, stall_cyc counts cycles spent in CHECK with a hazard
//     present, and issue_cnt counts unit handshakes. Both counters saturate.
//     When undefined, both ports are tied to zero.
//
// Ports
//   clk, rst                     clock, asynchronous active-low reset
//   ins_valid/ins_ready/ins      host instruction port
//   ld_ins_valid/ld_ins_ready    load-unit instruction handshake
//   pe_ins_valid/pe_ins_ready    PE-array instruction handshake
//   st_ins_valid/st_ins_ready    store-unit instruction handshake
//   unit_ins                     held instruction, shared by all unit ports
//   rx_done_buf_id/rx_done_pulse load completion for one buffer
//   pe_done                      per-PE done levels
//   st_done_pulse                store completion strobe
//   working                      busy or any work outstanding
//   err_illegal                  sticky illegal-opcode flag
//   stall_cyc, issue_cnt         performance counters
module ins_dispatch #(
   parameter int unsigned INST_W = 64,
   parameter int unsigned PE_NUM = 32,
   parameter int unsigned MAX_LD = 4,
   parameter int unsigned MAX_ST = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ins_valid,
   output logic              ins_ready,
   input  logic [INST_W-1:0] ins,
   output logic              ld_ins_valid,
   input  logic              ld_ins_ready,
   output logic              pe_ins_valid,
   input  logic              pe_ins_ready,
   output logic              st_ins_valid,
   input  logic              st_ins_ready,
   output logic [INST_W-1:0] unit_ins,
   input  logic [5:0]        rx_done_buf_id,
   input  logic              rx_done_pulse,
   input  logic [PE_NUM-1:0] pe_done,
   input  logic              st_done_pulse,
   output logic              working,
   output logic              err_illegal,
   output logic [31:0]       stall_cyc,
   output logic [31:0]       issue_cnt
);

   localparam int unsigned ST_W = $clog2(MAX_ST + 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CHECK = 2'd1,
      S_ISSUE = 2'd2,
      S_DRAIN = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [INST_W-1:0] ins_q;
   logic [63:0]       pend_q, pend_d;
   logic              cmp_busy_q, cmp_busy_d;
   logic [ST_W-1:0]   st_cnt_q, st_cnt_d;
   logic              err_q;
   logic              all_done_q;
   logic              done_rise_q;

   // Decode of the held instruction
   logic [3:0] opcode;
   logic [5:0] buf_id;
   logic       is_ld, is_cp, is_st, is_sync, is_ill;
   logic       hazard;
   logic       drained;
   logic       ld_hs, cp_hs, st_hs;
   logic [6:0] pend_cnt;

   function automatic logic [6:0] popcnt64(input logic [63:0] v);
      logic [6:0] c;
      c = '0;
      for (int unsigned i = 0; i < 64; i++) begin
         c = c + 7'(v[i]);
      end
      return c;
   endfunction

   assign opcode  = ins_q[INST_W-1 -: 4];
   assign buf_id  = ins_q[INST_W-5 -: 6];
   assign is_ld   = (opcode[3:2] == 2'b00);
   assign is_cp   = (opcode[3:2] == 2'b01);
   assign is_st   = (opcode[3:2] == 2'b10);
   assign is_sync = (opcode == 4'hF);
   assign is_ill  = (opcode[3:2] == 2'b11) && !is_sync;

   assign pend_cnt = popcnt64(pend_q);

   always_comb begin
      hazard = 1'b0;
      if (is_ld) begin
         hazard = pend_q[buf_id] || (pend_cnt >= 7'(MAX_LD));
      end else if (is_cp) begin
         hazard = pend_q[buf_id] || cmp_busy_q;
      end else if (is_st) begin
         hazard = cmp_busy_q || (st_cnt_q >= ST_W'(MAX_ST));
      end
   end

   assign drained = (pend_q == '0) && !cmp_busy_q && (st_cnt_q == '0);

   assign ld_hs = ld_ins_valid && ld_ins_ready;
   assign cp_hs = pe_ins_valid && pe_ins_ready;
   assign st_hs = st_ins_valid && st_ins_ready;

   // FSM: state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM: next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (ins_valid) state_d = S_CHECK;
         end
         S_CHECK: begin
            if (is_ill)       state_d = S_IDLE;
            else if (is_sync) state_d = S_DRAIN;
            else if (!hazard) state_d = S_ISSUE;
         end
         S_ISSUE: begin
            if (ld_hs || cp_hs || st_hs) state_d = S_IDLE;
         end
         S_DRAIN: begin
            if (drained) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      ins_ready    = 1'b0;
      ld_ins_valid = 1'b0;
      pe_ins_valid = 1'b0;
      st_ins_valid = 1'b0;
      case (state_q)
         S_IDLE:  ins_ready = 1'b1;
         S_ISSUE: begin
            ld_ins_valid = is_ld;
            pe_ins_valid = is_cp;
            st_ins_valid = is_st;
         end
         default: ;
      endcase
   end

   assign unit_ins    = ins_q;
   assign err_illegal = err_q;
   assign working     = (state_q != S_IDLE) || (pend_q != '0) || cmp_busy_q ||
                        (st_cnt_q != '0);

   // Held instruction and sticky error
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ins_q <= '0;
         err_q <= 1'b0;
      end else begin
         if (state_q == S_IDLE && ins_valid) ins_q <= ins;
         if (state_q == S_CHECK && is_ill)   err_q <= 1'b1;
      end
   end

   // Scoreboard: a set from the load handshake and a clear from rx_done may
   // hit different bits in the same cycle; the same bit cannot collide since
   // that load would have been stalled.
   always_comb begin
      pend_d = pend_q;
      if (rx_done_pulse) pend_d[rx_done_buf_id] = 1'b0;
      if (ld_hs)         pend_d[buf_id]         = 1'b1;
   end

   // Compute busy: the rising edge of &pe_done is registered, then clears the
   // flag one cycle later. A new COMP handshake takes priority over the clear.
   always_comb begin
      cmp_busy_d = cmp_busy_q;
      if (cp_hs)            cmp_busy_d = 1'b1;
      else if (done_rise_q) cmp_busy_d = 1'b0;
   end

   // Store credits: a done pulse at zero is dropped.
   always_comb begin
      st_cnt_d = st_cnt_q;
      if (st_hs && !(st_done_pulse && st_cnt_q != '0)) begin
         st_cnt_d = st_cnt_q + ST_W'(1);
      end else if (!st_hs && st_done_pulse && st_cnt_q != '0) begin
         st_cnt_d = st_cnt_q - ST_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pend_q      <= '0;
         cmp_busy_q  <= 1'b0;
         st_cnt_q    <= '0;
         all_done_q  <= 1'b0;
         done_rise_q <= 1'b0;
      end else begin
         pend_q      <= pend_d;
         cmp_busy_q  <= cmp_busy_d;
         st_cnt_q    <= st_cnt_d;
         all_done_q  <= &pe_done;
         done_rise_q <= (&pe_done) && !all_done_q;
      end
   end

`ifdef INS_DISPATCH_PERF_EN
   logic [31:0] stall_cyc_q, stall_cyc_d;
   logic [31:0] issue_cnt_q, issue_cnt_d;

   always_comb begin
      stall_cyc_d = stall_cyc_q;
      issue_cnt_d = issue_cnt_q;
      if (state_q == S_CHECK && !is_ill && !is_sync && hazard &&
          stall_cyc_q != '1) begin
         stall_cyc_d = stall_cyc_q + 32'd1;
      end
      if ((ld_hs || cp_hs || st_hs) && issue_cnt_q != '1) begin
         issue_cnt_d = issue_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cyc_q <= '0;
         issue_cnt_q <= '0;
      end else begin
         stall_cyc_q <= stall_cyc_d;
         issue_cnt_q <= issue_cnt_d;
      end
   end

   assign stall_cyc = stall_cyc_q;
   assign issue_cnt = issue_cnt_q;
`else
   assign stall_cyc = '0;
   assign issue_cnt = '0;
`endif

endmodule

// File: tb/tb_ins_dispatch.sv
module tb_ins_dispatch;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        ins_valid = 1'b0;
   logic        ins_ready;
   logic [63:0] ins = '0;
   logic        ld_ins_valid, pe_ins_valid, st_ins_valid;
   logic        ld_ins_ready = 1'b1;
   logic        pe_ins_ready = 1'b1;
   logic        st_ins_ready = 1'b1;
   logic [63:0] unit_ins;
   logic [5:0]  rx_done_buf_id = '0;
   logic        rx_done_pulse = 1'b0;
   logic [31:0] pe_done = '0;
   logic        st_done_pulse = 1'b0;
   logic        working, err_illegal;
   logic [31:0] stall_cyc, issue_cnt;

   int tests = 0;
   int fails = 0;
   int hs_cnt = 0;
   logic [65:0] exp_q[$];

   ins_dispatch #(.INST_W(64), .PE_NUM(32), .MAX_LD(4), .MAX_ST(4)) dut (
      .clk(clk), .rst(rst),
      .ins_valid(ins_valid), .ins_ready(ins_ready), .ins(ins),
      .ld_ins_valid(ld_ins_valid), .ld_ins_ready(ld_ins_ready),
      .pe_ins_valid(pe_ins_valid), .pe_ins_ready(pe_ins_ready),
      .st_ins_valid(st_ins_valid), .st_ins_ready(st_ins_ready),
      .unit_ins(unit_ins),
      .rx_done_buf_id(rx_done_buf_id), .rx_done_pulse(rx_done_pulse),
      .pe_done(pe_done), .st_done_pulse(st_done_pulse),
      .working(working), .err_illegal(err_illegal),
      .stall_cyc(stall_cyc), .issue_cnt(issue_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] mk(input logic [3:0] op, input logic [5:0] id);
      logic [53:0] pay;
      pay = {22'h0, 4'hA, id, op, 18'h1_2345};
      return {op, id, pay};
   endfunction

   // unit: 0 load, 1 compute, 2 store, 3 none (SYNC / illegal)
   task automatic send(input logic [63:0] w, input int unit);
      int n;
      n = 0;
      ins = w;
      ins_valid = 1'b1;
      while (!ins_ready && n < 200) begin
         step();
         n++;
      end
      chk("send_accept", 64'(ins_ready), 64'd1);
      if (unit < 3) exp_q.push_back({2'(unit), w});
      step();
      ins_valid = 1'b0;
   endtask

   function automatic logic unit_valid(input int u);
      case (u)
         0: return ld_ins_valid;
         1: return pe_ins_valid;
         default: return st_ins_valid;
      endcase
   endfunction

   task automatic wait_unit(input int u, input int budget, input string name);
      int n;
      n = 0;
      while (!unit_valid(u) && n < budget) begin
         step();
         n++;
      end
      chk(name, 64'(unit_valid(u)), 64'd1);
   endtask

   task automatic wait_idle(input int budget, input string name);
      int n;
      n = 0;
      while (working && n < budget) begin
         step();
         n++;
      end
      chk(name, 64'(working), 64'd0);
   endtask

   task automatic rx_done(input logic [5:0] id);
      rx_done_buf_id = id;
      rx_done_pulse = 1'b1;
      step();
      rx_done_pulse = 1'b0;
   endtask

   task automatic st_done();
      st_done_pulse = 1'b1;
      step();
      st_done_pulse = 1'b0;
      step();
   endtask

   task automatic pe_finish();
      pe_done = '1;
      step();
      step();
      pe_done = '0;
   endtask

   // Monitor: compares every unit handshake against the expected stream.
   int          mon_nv;
   logic [1:0]  mon_u;
   logic [65:0] mon_e;
   always @(negedge clk) begin
      if (rst) begin
         mon_nv = int'(ld_ins_valid) + int'(pe_ins_valid) + int'(st_ins_valid);
         if (mon_nv != 0) begin
            tests++;
            if (mon_nv > 1) begin
               fails++;
               $display("FAIL one_hot_valid: got %0d valids expected 1", mon_nv);
            end
         end
         if ((ld_ins_valid && ld_ins_ready) || (pe_ins_valid && pe_ins_ready) ||
             (st_ins_valid && st_ins_ready)) begin
            mon_u = ld_ins_valid ? 2'd0 : (pe_ins_valid ? 2'd1 : 2'd2);
            hs_cnt++;
            tests++;
            if (exp_q.size() == 0) begin
               fails++;
               $display("FAIL handshake: got unit %0d ins %h expected none", mon_u, unit_ins);
            end else begin
               mon_e = exp_q.pop_front();
               if ({mon_u, unit_ins} !== mon_e) begin
                  fails++;
                  $display("FAIL handshake: got unit %0d ins %h expected unit %0d ins %h",
                           mon_u, unit_ins, mon_e[65:64], mon_e[63:0]);
               end
            end
         end
      end
   end

   initial begin
      // Reset
      repeat (3) step();
      chk("rst_valids", {61'd0, ld_ins_valid, pe_ins_valid, st_ins_valid}, 64'd0);
      rst = 1'b1;
      step();
      chk("rst_ins_ready", 64'(ins_ready), 64'd1);
      chk("rst_working", 64'(working), 64'd0);
      chk("rst_err", 64'(err_illegal), 64'd0);
      chk("rst_unit_ins", unit_ins, 64'd0);

      // T1: LOAD buf 5
      send(mk(4'd0, 6'd5), 0);
      chk("t1_valid_n1", 64'(ld_ins_valid), 64'd0);
      step();
      chk("t1_valid_n2", 64'(ld_ins_valid), 64'd1);
      step();
      chk("t1_working", 64'(working), 64'd1);

      // T2: COMP buf 5 stalls on pending load
      send(mk(4'd5, 6'd5), 1);
      repeat (4) step();
      chk("t2_stall_valid", 64'(pe_ins_valid), 64'd0);
      chk("t2_stall_ready", 64'(ins_ready), 64'd0);
      rx_done(6'd5);
      chk("t2_not_yet", 64'(pe_ins_valid), 64'd0);
      step();
      chk("t2_issue", 64'(pe_ins_valid), 64'd1);
      step();
      chk("t2_cmp_busy", 64'(working), 64'd1);
      pe_finish();
      wait_idle(10, "t2_idle");

      // T3: store credit limit
      for (int i = 0; i < 4; i++) begin
         send(mk(4'd8 + 4'(i), 6'(20 + i)), 2);
         wait_unit(2, 5, "t3_store_issue");
         step();
      end
      send(mk(4'd11, 6'd30), 2);
      repeat (5) step();
      chk("t3_fifth_stall", 64'(st_ins_valid), 64'd0);
      chk("t3_fifth_ready", 64'(ins_ready), 64'd0);
      st_done();
      wait_unit(2, 4, "t3_fifth_issue");
      step();
      repeat (3) st_done();
      chk("t3_cnt_left_one", 64'(working), 64'd1);
      st_done();
      chk("t3_cnt_zero", 64'(working), 64'd0);

      // T4: SYNC drains load, compute and store
      send(mk(4'd1, 6'd7), 0);
      wait_unit(0, 5, "t4_load");
      step();
      send(mk(4'd9, 6'd1), 2);
      wait_unit(2, 5, "t4_store");
      step();
      send(mk(4'd6, 6'd9), 1);
      wait_unit(1, 5, "t4_comp");
      step();
      send(mk(4'd15, 6'd0), 3);
      step();
      chk("t4_drain_a", 64'(ins_ready), 64'd0);
      rx_done(6'd7);
      repeat (3) step();
      chk("t4_drain_b", 64'(ins_ready), 64'd0);
      pe_finish();
      repeat (3) step();
      chk("t4_drain_c", 64'(ins_ready), 64'd0);
      st_done();
      begin
         int n;
         n = 0;
         while (!ins_ready && n < 10) begin
            step();
            n++;
         end
      end
      chk("t4_ready", 64'(ins_ready), 64'd1);
      chk("t4_working", 64'(working), 64'd0);

      // T5: illegal opcode
      send(mk(4'd13, 6'd4), 3);
      repeat (3) step();
      chk("t5_err", 64'(err_illegal), 64'd1);
      chk("t5_ready", 64'(ins_ready), 64'd1);
      chk("t5_working", 64'(working), 64'd0);
      send(mk(4'd2, 6'd2), 0);
      wait_unit(0, 5, "t5_load");
      step();
      chk("t5_err_sticky", 64'(err_illegal), 64'd1);
      rx_done(6'd2);
      wait_idle(5, "t5_idle");

      // T7: load limit and same-buffer hazard
      for (int i = 0; i < 4; i++) begin
         send(mk(4'd3, 6'(10 + i)), 0);
         wait_unit(0, 5, "t7_load");
         step();
      end
      send(mk(4'd0, 6'd14), 0);
      repeat (4) step();
      chk("t7_max_ld_stall", 64'(ld_ins_valid), 64'd0);
      rx_done(6'd10);
      wait_unit(0, 4, "t7_after_free");
      step();
      rx_done(6'd12);
      send(mk(4'd0, 6'd11), 0);
      repeat (4) step();
      chk("t7_same_buf_stall", 64'(ld_ins_valid), 64'd0);
      rx_done(6'd11);
      wait_unit(0, 4, "t7_same_buf_issue");
      step();
      rx_done(6'd11);
      rx_done(6'd13);
      rx_done(6'd14);
      wait_idle(5, "t7_idle");

`ifdef INS_DISPATCH_PERF_EN
      chk("perf_issue", issue_cnt, 64'(hs_cnt));
      chk("perf_stall_nz", 64'(stall_cyc != 0), 64'd1);
`else
      chk("perf_issue_tied", 64'(issue_cnt), 64'd0);
      chk("perf_stall_tied", 64'(stall_cyc), 64'd0);
`endif

      // T6: reset while a store is held
      send(mk(4'd0, 6'd3), 0);
      wait_unit(0, 5, "t6_load");
      step();
      st_ins_ready = 1'b0;
      send(mk(4'd10, 6'd6), 2);
      wait_unit(2, 5, "t6_store_held");
      rst = 1'b0;
      exp_q.delete();
      step();
      chk("t6_valids", {61'd0, ld_ins_valid, pe_ins_valid, st_ins_valid}, 64'd0);
      chk("t6_working", 64'(working), 64'd0);
      chk("t6_unit_ins", unit_ins, 64'd0);
      chk("t6_err_clr", 64'(err_illegal), 64'd0);
      rst = 1'b1;
      st_ins_ready = 1'b1;
      step();
      chk("t6_ready", 64'(ins_ready), 64'd1);
      chk("t6_working_after", 64'(working), 64'd0);
      send(mk(4'd8, 6'd1), 2);
      wait_unit(2, 5, "t6_store_after");
      step();
      st_done();
      wait_idle(5, "t6_idle");

      chk("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
